ste_dma_sound_ctrl: RTL and testbench
=====================================

STE_DMA_SOUND_CTRL -- requirements
Module: ste_dma_sound_ctrl

Interface
REQ-001 clk32  in  1  system clock; all logic rising-edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 reg_we  in  1  one-cycle register write strobe.
REQ-004 reg_addr  in  3  register select: 0 ctrl, 1 start_hi, 2 start_lo, 3 end_hi, 4 end_lo, 5 cnt_hi, 6 cnt_lo.
REQ-005 reg_din  in  16  write data.
REQ-006 reg_dout  out  16  combinational readback of the register selected by reg_addr; 0 for reg_addr 7.
REQ-007 slot  in  1  one-cycle pulse: bus memory slot available for sound fetch.
REQ-008 sreq  in  1  shifter audio FIFO has room; sampled only at slot.
REQ-009 mem_req  out  1  fetch in progress; mem_addr valid.
REQ-010 mem_addr  out  23  word address [23:1] of the current fetch.
REQ-011 mem_ack  in  1  fetched word present on the shifter RAM input this cycle.
REQ-012 sload_n  out  1  active-low one-cycle FIFO load strobe to the shifter.
REQ-013 active  out  1  playback running (ctrl.enable).
REQ-014 frame_irq  out  1  one-cycle pulse at end of frame.

Function
REQ-015 Registers: ctrl[0]=enable, ctrl[1]=loop; start/end are 23-bit word addresses; *_hi holds din[7:0] -> addr[23:16]; *_lo holds din[15:1] -> addr[15:1]; din[0] ignored; readback of *_lo returns bit0=0.
REQ-016 cnt_hi/cnt_lo are read-only readbacks of the live counter; writes to them are ignored.
REQ-017 States: IDLE, WAIT, FETCH, LOAD, CHECK.
REQ-018 Enable rising (ctrl write with enable 0->1 while IDLE): latch start_sh<=start, end_sh<=end, counter<=start; go to CHECK.
REQ-019 CHECK: if counter >= end_sh (unsigned, 23 bit), frame end (REQ-023); else go to WAIT.
REQ-020 WAIT: if slot && sreq && enable -> FETCH; slot without sreq is dropped with no state change.
REQ-021 FETCH: mem_req=1, mem_addr=counter; hold until mem_ack; on mem_ack go to LOAD; no timeout.
REQ-022 LOAD: sload_n=0 for exactly this one cycle; counter<=counter+1 (wraps 0x7FFFFF->0); go to CHECK.
REQ-023 Frame end: frame_irq=1 for one cycle; if loop && enable && start<end (live regs), re-latch shadows, counter<=start, go to WAIT; else clear enable, go to IDLE.
REQ-024 Empty frame (start>=end at enable): no fetch, one frame_irq, enable cleared even with loop set.
REQ-025 Writes to start/end during playback affect only the next latch (loop or re-enable).
REQ-026 Enable cleared by write in WAIT/CHECK: go to IDLE next cycle, no frame_irq; in FETCH: complete fetch and LOAD, then IDLE, no frame_irq.
REQ-027 Writing enable=1 while already active: no effect (no re-latch).
REQ-028 active mirrors ctrl.enable with zero latency after the register update.
REQ-029 Fetch latency: mem_req asserts the cycle after the qualifying slot; sload_n low the cycle after mem_ack.
REQ-030 At most one word fetched per slot pulse.

Reset
REQ-031 On rst: state IDLE, ctrl=0, start=end=counter=shadows=0, mem_req=0, mem_addr=0, sload_n=1, active=0, frame_irq=0.
REQ-032 rst mid-FETCH aborts immediately; no sload_n pulse is issued afterwards.

Verification
REQ-033 start=0x000100, end=0x000103, loop=0, enable; slot+sreq with mem_ack one cycle later, three times -> mem_addr 0x100,0x101,0x102, three sload_n pulses, one frame_irq, active=0, cnt=0x103.
REQ-034 Same frame with loop=1 -> after third load, frame_irq pulses, next fetch at 0x100; end rewritten to 0x000101 mid-frame takes effect only on the second pass.
REQ-035 slot pulses with sreq=0 -> no mem_req, counter unchanged; sreq=1 on the next slot -> fetch proceeds.
REQ-036 start=end=0x000200, loop=1, enable -> no mem_req, one frame_irq, active=0.
REQ-037 Enable cleared while in FETCH with mem_ack delayed 5 cycles -> mem_req held, single sload_n, then IDLE, no frame_irq; rst asserted during FETCH in a rerun -> all outputs at reset values next cycle.
REQ-038 start=0x7FFFFF, end=0x7FFFFF+0 wrap check: start=0x7FFFFE, end=0x7FFFFF -> one fetch at 0x7FFFFE, frame_irq, cnt=0x7FFFFF.

Source files
------------

// File: rtl/ste_dma_sound_ctrl.sv
// STE DMA sound fetch controller: register file plus a fetch sequencer that walks
// a word-address frame, issuing one memory fetch and one shifter FIFO load per slot.
module ste_dma_sound_ctrl (
  input  logic        clk32,
  input  logic        rst,
  input  logic        reg_we,
  input  logic [2:0]  reg_addr,
  input  logic [15:0] reg_din,
  output logic [15:0] reg_dout,
  input  logic        slot,
  input  logic        sreq,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  input  logic        mem_ack,
  output logic        sload_n,
  output logic        active,
  output logic        frame_irq
);

  typedef enum logic [2:0] {IDLE, WAIT, FETCH, LOAD, CHECK} state_t;

  state_t      state;
  logic        enable;
  logic        loop;
  logic [22:0] start_r;
  logic [22:0] end_r;
  logic [22:0] end_sh;
  logic [22:0] cnt;

  logic ctrl_wr;
  logic en_next;
  logic loop_next;

  // Decisions in the sequencer see a ctrl write landing this same cycle.
  assign ctrl_wr   = reg_we && (reg_addr == 3'd0);
  assign en_next   = ctrl_wr ? reg_din[0] : enable;
  assign loop_next = ctrl_wr ? reg_din[1] : loop;
  assign active    = enable;

  always_comb begin
    reg_dout = 16'h0000;
    case (reg_addr)
      3'd0: reg_dout = {14'h0000, loop, enable};
      3'd1: reg_dout = {8'h00, start_r[22:15]};
      3'd2: reg_dout = {start_r[14:0], 1'b0};
      3'd3: reg_dout = {8'h00, end_r[22:15]};
      3'd4: reg_dout = {end_r[14:0], 1'b0};
      3'd5: reg_dout = {8'h00, cnt[22:15]};
      3'd6: reg_dout = {cnt[14:0], 1'b0};
      default: reg_dout = 16'h0000;
    endcase
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      state     <= IDLE;
      enable    <= 1'b0;
      loop      <= 1'b0;
      start_r   <= '0;
      end_r     <= '0;
      end_sh    <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      sload_n   <= 1'b1;
      frame_irq <= 1'b0;
    end else begin
      frame_irq <= 1'b0;

      if (reg_we) begin
        case (reg_addr)
          3'd0: begin
            enable <= reg_din[0];
            loop   <= reg_din[1];
          end
          3'd1: start_r[22:15] <= reg_din[7:0];
          3'd2: start_r[14:0]  <= reg_din[15:1];
          3'd3: end_r[22:15]   <= reg_din[7:0];
          3'd4: end_r[14:0]    <= reg_din[15:1];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (ctrl_wr && reg_din[0] && !enable) begin
            end_sh <= end_r;
            cnt    <= start_r;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (!en_next) begin
            state <= IDLE;
          end else if (cnt >= end_sh) begin
            frame_irq <= 1'b1;
            // Looping re-reads the live start/end so mid-frame rewrites apply here.
            if (loop_next && (start_r < end_r)) begin
              end_sh <= end_r;
              cnt    <= start_r;
              state  <= WAIT;
            end else begin
              enable <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!en_next) begin
            state <= IDLE;
          end else if (slot && sreq) begin
            mem_req  <= 1'b1;
            mem_addr <= cnt;
            state    <= FETCH;
          end
        end
        FETCH: begin
          // A started fetch always completes, even if playback was disabled meanwhile.
          if (mem_ack) begin
            mem_req <= 1'b0;
            sload_n <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          sload_n <= 1'b1;
          cnt     <= cnt + 23'd1;
          state   <= en_next ? CHECK : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_dma_sound_ctrl.sv
// Scoreboard bench for ste_dma_sound_ctrl: stimulus pushes expected fetch/load/irq
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_ste_dma_sound_ctrl;

  logic        clk32 = 1'b0;
  logic        rst;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [15:0] reg_din;
  logic [15:0] reg_dout;
  logic        slot;
  logic        sreq;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic        mem_ack;
  logic        sload_n;
  logic        active;
  logic        frame_irq;

  ste_dma_sound_ctrl dut (
    .clk32(clk32), .rst(rst), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_din(reg_din), .reg_dout(reg_dout), .slot(slot), .sreq(sreq),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .sload_n(sload_n), .active(active), .frame_irq(frame_irq)
  );

  always #5 clk32 = ~clk32;

  localparam int EV_FETCH = 0;
  localparam int EV_LOAD  = 1;
  localparam int EV_IRQ   = 2;

  typedef struct {
    int          kind;
    logic [22:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int k, input logic [22:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [22:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr %0h expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (k == EV_FETCH && e.kind == EV_FETCH)
        chk("fetch_addr", {9'h000, v}, {9'h000, e.val});
    end
  endtask

  // Monitor: samples outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk32);
      if (rst) begin
        mon_prev_req = 1'b0;
      end else begin
        if (mem_req && !mon_prev_req) observe(EV_FETCH, mem_addr);
        if (!sload_n) observe(EV_LOAD, 23'h0);
        if (frame_irq) observe(EV_IRQ, 23'h0);
        mon_prev_req = mem_req;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk32);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    reg_we   = 1'b1;
    reg_addr = a;
    reg_din  = d;
    step();
    reg_we   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] req);
    reg_addr = a;
    #1;
    chk(name, {16'h0000, reg_dout}, {16'h0000, req});
  endtask

  task automatic rd_cnt(output logic [22:0] c);
    logic [15:0] hi;
    reg_addr = 3'd5;
    #1;
    hi = reg_dout;
    reg_addr = 3'd6;
    #1;
    c = {hi[7:0], reg_dout[15:1]};
  endtask

  // Bit 0 of the low half is set on purpose: hardware must ignore it.
  task automatic set_addr(input logic [2:0] hi, input logic [22:0] a);
    logic [2:0] lo;
    lo = hi + 3'd1;
    wr(hi, {8'h00, a[22:15]});
    wr(lo, {a[14:0], 1'b1});
  endtask

  task automatic slot_pulse(input logic s);
    slot = 1'b1;
    sreq = s;
    step();
    slot = 1'b0;
    sreq = 1'b0;
  endtask

  task automatic serve(input int d);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    if (!mem_req) begin
      checks++;
      errors++;
      $display("FAIL mem_req_timeout: got 0 expected 1");
    end
    repeat (d) begin
      step();
      chk("mem_req_held", 32'(mem_req), 32'd1);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    repeat (3) step();
  endtask

  // Model: a frame fetches each word address s..e-1 once, then raises one irq.
  task automatic play_frame(input int unsigned s, input int unsigned e, input int maxd);
    logic [22:0] c;
    for (int unsigned a = s; a < e; a++) begin
      if ($urandom_range(0, 2) == 0) begin
        slot_pulse(1'b0);
        chk("drop_no_req", 32'(mem_req), 32'd0);
        rd_cnt(c);
        chk("drop_cnt", {9'h000, c}, a);
        step();
      end
      expect_ev(EV_FETCH, a[22:0]);
      expect_ev(EV_LOAD, 23'h0);
      if (a + 1 == e) expect_ev(EV_IRQ, 23'h0);
      slot_pulse(1'b1);
      serve(int'($urandom_range(0, maxd)));
    end
  endtask

  initial begin
    logic [22:0] c;
    int unsigned s;
    int unsigned e;
    int unsigned len;

    rst = 1'b1; reg_we = 1'b0; reg_addr = 3'd0; reg_din = 16'h0000;
    slot = 1'b0; sreq = 1'b0; mem_ack = 1'b0;
    repeat (3) step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", {9'h000, mem_addr}, 32'd0);
    chk("rst_sload_n", 32'(sload_n), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_frame_irq", 32'(frame_irq), 32'd0);
    for (int i = 0; i < 8; i++) rd_chk("rst_reg", 3'(i), 16'h0000);
    rst = 1'b0;
    step();

    // Register readback formatting and read-only counter
    wr(3'd1, 16'hAB12);
    wr(3'd2, 16'h3457);
    wr(3'd5, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
    rd_chk("start_hi_rb", 3'd1, 16'h0012);
    rd_chk("start_lo_rb", 3'd2, 16'h3456);
    rd_chk("cnt_hi_ro", 3'd5, 16'h0000);
    rd_chk("cnt_lo_ro", 3'd6, 16'h0000);
    rd_chk("reg7_zero", 3'd7, 16'h0000);

    // Basic single-shot frame with a dropped slot first
    set_addr(3'd1, 23'h000100);
    set_addr(3'd3, 23'h000103);
    wr(3'd0, 16'h0001);
    chk("active_zero_latency", 32'(active), 32'd1);
    step(); step();
    slot_pulse(1'b0);
    chk("sreq0_no_req", 32'(mem_req), 32'd0);
    step();
    play_frame(32'h100, 32'h103, 1);
    chk("single_active_off", 32'(active), 32'd0);
    rd_cnt(c);
    chk("single_cnt", {9'h000, c}, 32'h103);

    // Looping frame; end rewritten mid-frame applies only on the next pass
    wr(3'd0, 16'h0003);
    step(); step();
    expect_ev(EV_FETCH, 23'h000100);
    expect_ev(EV_LOAD, 23'h0);
    slot_pulse(1'b1);
    set_addr(3'd3, 23'h000101);
    serve(1);
    play_frame(32'h101, 32'h103, 2);
    chk("loop_still_active", 32'(active), 32'd1);
    wr(3'd0, 16'h0001);
    expect_ev(EV_FETCH, 23'h000100);
    expect_ev(EV_LOAD, 23'h0);
    expect_ev(EV_IRQ, 23'h0);
    slot_pulse(1'b1);
    serve(0);
    chk("loop_end_active", 32'(active), 32'd0);
    rd_cnt(c);
    chk("loop_cnt", {9'h000, c}, 32'h101);

    // Empty frame with loop set
    set_addr(3'd1, 23'h000200);
    set_addr(3'd3, 23'h000200);
    expect_ev(EV_IRQ, 23'h0);
    wr(3'd0, 16'h0003);
    repeat (4) step();
    chk("empty_active", 32'(active), 32'd0);
    chk("empty_no_req", 32'(mem_req), 32'd0);
    rd_chk("empty_ctrl", 3'd0, 16'h0002);

    // Top of address space
    set_addr(3'd1, 23'h7FFFFE);
    set_addr(3'd3, 23'h7FFFFF);
    wr(3'd0, 16'h0001);
    step(); step();
    play_frame(32'h7FFFFE, 32'h7FFFFF, 1);
    rd_cnt(c);
    chk("top_cnt", {9'h000, c}, 32'h7FFFFF);
    chk("top_active", 32'(active), 32'd0);

    // Disable during a slow fetch: fetch completes, no irq
    set_addr(3'd1, 23'h000300);
    set_addr(3'd3, 23'h000305);
    wr(3'd0, 16'h0001);
    step(); step();
    expect_ev(EV_FETCH, 23'h000300);
    expect_ev(EV_LOAD, 23'h0);
    slot_pulse(1'b1);
    chk("dis_req_up", 32'(mem_req), 32'd1);
    wr(3'd0, 16'h0000);
    chk("dis_active", 32'(active), 32'd0);
    serve(5);
    slot_pulse(1'b1);
    chk("dis_idle_no_req", 32'(mem_req), 32'd0);
    rd_cnt(c);
    chk("dis_cnt", {9'h000, c}, 32'h301);

    // Reset in the middle of a fetch
    expect_ev(EV_FETCH, 23'h000300);
    wr(3'd0, 16'h0001);
    step(); step();
    slot_pulse(1'b1);
    chk("rst_fetch_up", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    chk("rstf_mem_req", 32'(mem_req), 32'd0);
    chk("rstf_mem_addr", {9'h000, mem_addr}, 32'd0);
    chk("rstf_sload_n", 32'(sload_n), 32'd1);
    chk("rstf_active", 32'(active), 32'd0);
    chk("rstf_frame_irq", 32'(frame_irq), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) step();
    rd_chk("rstf_start_lo", 3'd2, 16'h0000);

    // Randomized frames, including empty and wrapped-end ones
    for (int it = 0; it < 10; it++) begin
      s   = $urandom & 32'h7FFFFF;
      len = $urandom_range(0, 4);
      if (it == 0) s = 32'h7FFFFD;
      e   = (s + len) & 32'h7FFFFF;
      set_addr(3'd1, s[22:0]);
      set_addr(3'd3, e[22:0]);
      if (!(s < e)) expect_ev(EV_IRQ, 23'h0);
      wr(3'd0, 16'h0001);
      step(); step();
      if (s < e) play_frame(s, e, 3);
      else repeat (3) step();
      chk("rand_active", 32'(active), 32'd0);
      rd_cnt(c);
      chk("rand_cnt", {9'h000, c}, (s < e) ? e : s);
    end

    repeat (5) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
